// File: rtl/map_render_pkg.sv
// Shared terrain-map definitions: grid geometry, cell types, colours and scan-to-cell helpers.
// Declarations only; no latency.
// No flow control; reused by the tank and bullet logic that share the 5-bit grid.
package map_render_pkg;

  localparam int CELL_PX   = 20;
  localparam int GRID_W    = 32;
  localparam int GRID_H    = 24;
  localparam int H_ACTIVE  = 640;
  localparam int V_ACTIVE  = 480;
  localparam int MAP_CELLS = GRID_W * GRID_H;
  localparam int ADDR_W    = 10;

  localparam logic [1:0] CELL_EMPTY = 2'd0;
  localparam logic [1:0] CELL_BRICK = 2'd1;
  localparam logic [1:0] CELL_STEEL = 2'd2;
  localparam logic [1:0] CELL_WATER = 2'd3;

  localparam logic [11:0] COL_BRICK      = 12'hA40;
  localparam logic [11:0] COL_MORTAR     = 12'h888;
  localparam logic [11:0] COL_STEEL      = 12'hCCC;
  localparam logic [11:0] COL_STEEL_EDGE = 12'h666;
  localparam logic [11:0] COL_WATER      = 12'h05F;

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_WRITE} map_state_t;

  // x/20 computed as ((x>>2)*205)>>10, exact while x>>2 < 1024, i.e. for any 11-bit x.
  function automatic logic [4:0] div20(input logic [10:0] v);
    return 5'((18'(v[10:2]) * 18'd205) >> 10);
  endfunction

  function automatic logic [4:0] mod20(input logic [10:0] v, input logic [4:0] q);
    return 5'(v - 11'(q) * 11'd20);
  endfunction

  function automatic logic [11:0] cell_colour(input logic [1:0] t,
                                              input logic [4:0] ox,
                                              input logic [4:0] oy);
    logic [11:0] c;
    c = 12'h000;
    case (t)
      CELL_BRICK: c = (oy == 5'd0 || oy == 5'd10 || (ox == 5'd0 && oy < 5'd10) ||
                       (ox == 5'd10 && oy >= 5'd10)) ? COL_MORTAR : COL_BRICK;
      CELL_STEEL: c = (ox == 5'd0 || ox == 5'd19 || oy == 5'd0 || oy == 5'd19) ?
                      COL_STEEL_EDGE : COL_STEEL;
      CELL_WATER: c = COL_WATER;
      default:    c = 12'h000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/map_ram.sv
// 768x2 terrain store: one write port plus synchronous render, collision (and hit) read ports.
// Reads return registered data one clock after the address; a same-cycle write is seen next cycle.
// No backpressure; every port is serviced every clock.
module map_ram
  import map_render_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [1:0]        wr_dat,
  input  logic [ADDR_W-1:0] rnd_addr,
  output logic [1:0]        rnd_dat,
  input  logic [ADDR_W-1:0] col_addr,
  output logic [1:0]        col_dat
`ifdef MAP_RENDER_DESTROY_EN
  ,
  input  logic [ADDR_W-1:0] hit_addr,
  output logic [1:0]        hit_dat
`endif
);

  logic [1:0] mem [MAP_CELLS];

  // Storage carries no reset so it stays in distributed RAM; the init sweep fills it.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rnd_dat <= CELL_EMPTY;
      col_dat <= CELL_EMPTY;
    end else begin
      rnd_dat <= mem[rnd_addr];
      col_dat <= mem[col_addr];
    end
  end

`ifdef MAP_RENDER_DESTROY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hit_dat <= CELL_EMPTY;
    else     hit_dat <= mem[hit_addr];
  end
`endif

endmodule

// File: rtl/map_render.sv
// Terrain layer: 32x24 map with edit/collision ports and a 2-clock pixel render; MAP_RENDER_DESTROY_EN adds bullet hits.
// Latency: pixel 2 clk, rd_type 1 clk, write ack 2 clk after wr_req (3 if a brick hit collides).
// Backpressure: wr_req held until the one-cycle wr_ack; writes ignored while busy (init sweep).
module map_render
  import map_render_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] VGA_xpos,
  input  logic [10:0] VGA_ypos,
  output logic [11:0] VGA_data,
  output logic        VGA_en,
  input  logic        wr_req,
  input  logic [4:0]  wr_x,
  input  logic [4:0]  wr_y,
  input  logic [1:0]  wr_type,
  output logic        wr_ack,
  input  logic [4:0]  rd_x,
  input  logic [4:0]  rd_y,
  output logic [1:0]  rd_type,
  output logic        busy
`ifdef MAP_RENDER_DESTROY_EN
  ,
  input  logic        hit_valid,
  input  logic [4:0]  hit_x,
  input  logic [4:0]  hit_y,
  output logic        hit_wall
`endif
);

  map_state_t        state, state_nxt;
  logic [ADDR_W-1:0] init_cnt;
  logic [4:0]        init_x, init_y;
  logic              hit_wr;
  logic [ADDR_W-1:0] hit_addr_q;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [1:0]        ram_wdat;

  logic [4:0]        cx, cy, ox, oy, ox_q, oy_q;
  logic              act, act_q;
  logic [ADDR_W-1:0] rnd_addr, col_addr;
  logic [1:0]        rnd_dat, col_dat;
  logic              col_oob, col_oob_q;

  assign busy   = (state == ST_INIT);
  assign init_x = init_cnt[4:0];
  assign init_y = init_cnt[9:5];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_INIT;
      init_cnt <= '0;
      wr_ack   <= 1'b0;
    end else begin
      state  <= state_nxt;
      wr_ack <= (state == ST_WRITE) && !hit_wr;
      if (state == ST_INIT) init_cnt <= init_cnt + 10'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT:  if (init_cnt == 10'(MAP_CELLS - 1)) state_nxt = ST_IDLE;
      ST_IDLE:  if (wr_req) state_nxt = ST_WRITE;
      ST_WRITE: if (!hit_wr) state_nxt = ST_IDLE;
      default:  state_nxt = ST_INIT;
    endcase
  end

  // Single write port: init sweep, then a brick hit, then the deferred-able game write.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = init_cnt;
    ram_wdat  = CELL_EMPTY;
    if (state == ST_INIT) begin
      ram_we   = 1'b1;
      ram_wdat = (init_x == 5'd0 || init_x == 5'(GRID_W - 1) ||
                  init_y == 5'd0 || init_y == 5'(GRID_H - 1)) ? CELL_STEEL : CELL_EMPTY;
    end else if (hit_wr) begin
      ram_we    = 1'b1;
      ram_waddr = hit_addr_q;
    end else if (state == ST_WRITE && wr_y < 5'(GRID_H)) begin
      ram_we    = 1'b1;
      ram_waddr = {wr_y, wr_x};
      ram_wdat  = wr_type;
    end
  end

  // Render S1: cell lookup address goes straight to the RAM; offsets ride alongside.
  assign cx       = div20(VGA_xpos);
  assign cy       = div20(VGA_ypos);
  assign ox       = mod20(VGA_xpos, cx);
  assign oy       = mod20(VGA_ypos, cy);
  assign act      = (VGA_xpos < 11'(H_ACTIVE)) && (VGA_ypos < 11'(V_ACTIVE));
  assign rnd_addr = act ? {cy, cx} : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ox_q     <= '0;
      oy_q     <= '0;
      act_q    <= 1'b0;
      VGA_data <= 12'h000;
      VGA_en   <= 1'b0;
    end else begin
      ox_q     <= ox;
      oy_q     <= oy;
      act_q    <= act;
      VGA_data <= (act_q && !busy) ? cell_colour(rnd_dat, ox_q, oy_q) : 12'h000;
      VGA_en   <= act_q && !busy && (rnd_dat != CELL_EMPTY);
    end
  end

  // Rows past the map read as steel so off-map space is solid.
  assign col_oob  = (rd_y >= 5'(GRID_H));
  assign col_addr = col_oob ? '0 : {rd_y, rd_x};
  assign rd_type  = col_oob_q ? CELL_STEEL : col_dat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) col_oob_q <= 1'b0;
    else     col_oob_q <= col_oob;
  end

`ifdef MAP_RENDER_DESTROY_EN
  logic              hit_vld_q;
  logic [1:0]        hit_dat;
  logic [ADDR_W-1:0] hit_raddr;
  logic              hit_in_map;

  assign hit_in_map = (hit_y < 5'(GRID_H));
  assign hit_raddr  = hit_in_map ? {hit_y, hit_x} : '0;
  assign hit_wr     = hit_vld_q && (hit_dat == CELL_BRICK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_vld_q  <= 1'b0;
      hit_addr_q <= '0;
      hit_wall   <= 1'b0;
    end else begin
      hit_vld_q  <= hit_valid && hit_in_map && !busy;
      hit_addr_q <= hit_raddr;
      hit_wall   <= hit_vld_q && (hit_dat == CELL_BRICK || hit_dat == CELL_STEEL);
    end
  end
`else
  assign hit_wr     = 1'b0;
  assign hit_addr_q = '0;
`endif

  map_ram u_ram (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (ram_we),
    .wr_addr  (ram_waddr),
    .wr_dat   (ram_wdat),
    .rnd_addr (rnd_addr),
    .rnd_dat  (rnd_dat),
    .col_addr (col_addr),
    .col_dat  (col_dat)
`ifdef MAP_RENDER_DESTROY_EN
    ,
    .hit_addr (hit_raddr),
    .hit_dat  (hit_dat)
`endif
  );

endmodule
